// File: rtl/dircc_node_debug_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dircc_node_debug_mem_arbiter
// Brief    : Round-robin arbiter sharing the single-port debug OCI RAM between
//            the JTAG debug-slave command path and the Avalon debug_mem_slave.
// Revision : 1.0 - initial release
// ============================================================================
module dircc_node_debug_mem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  // JTAG debug-slave command path
  input  logic              jtag_req,
  input  logic              jtag_write,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [31:0]       jtag_wdata,
  input  logic              jtag_clr_overrun,
  output logic [31:0]       jtag_rdata,
  output logic              jtag_done,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  // Avalon-MM debug_mem_slave
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  // OCI RAM
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RDATA = 2'd2
  } state_t;

  localparam logic C_GNT_JTAG = 1'b0;
  localparam logic C_GNT_AV   = 1'b1;

  state_t            r_state;
  state_t            w_state_nxt;

  // r_grant is both the owner of the access in flight and the round-robin
  // history: it only changes when a new access starts.
  logic              r_grant;
  logic              r_is_write;

  logic              r_jtag_pend;
  logic              r_jtag_write;
  logic [ADDR_W-1:0] r_jtag_addr;
  logic [31:0]       r_jtag_wdata;
  logic              r_jtag_done;
  logic              r_jtag_overrun;
  logic [31:0]       r_jtag_rdata;

  logic [ADDR_W-1:0] r_ram_addr_hold;
  logic [3:0]        r_ram_be_hold;
  logic [31:0]       r_ram_wdata_hold;

  logic              w_av_req;
  logic              w_start;
  logic              w_sel;
  logic              w_issue;
  logic              w_complete;
  logic              w_jtag_complete;
  logic              w_jtag_accept;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [3:0]        w_issue_be;
  logic [31:0]       w_issue_wdata;

  assign w_av_req = av_read | av_write;

  // --------------------------------------------------------------------------
  // Access sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_sel       = C_GNT_AV;
    w_issue     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_jtag_pend && w_av_req) begin
          w_sel = (r_grant == C_GNT_AV) ? C_GNT_JTAG : C_GNT_AV;
        end else if (r_jtag_pend) begin
          w_sel = C_GNT_JTAG;
        end
        if (r_jtag_pend || w_av_req) begin
          w_start     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_issue = 1'b1;
        if (r_is_write) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RDATA;
        end
      end
      S_RDATA: begin
        w_complete  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Avalon write wins over a simultaneous Avalon read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant    <= C_GNT_AV;
      r_is_write <= 1'b0;
    end else if (w_start) begin
      r_grant    <= w_sel;
      r_is_write <= (w_sel == C_GNT_JTAG) ? r_jtag_write : av_write;
    end
  end

  // --------------------------------------------------------------------------
  // JTAG request capture, completion and overrun tracking
  // --------------------------------------------------------------------------
  assign w_jtag_complete = w_complete && (r_grant == C_GNT_JTAG);
  assign w_jtag_accept   = jtag_req && !r_jtag_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jtag_pend    <= 1'b0;
      r_jtag_write   <= 1'b0;
      r_jtag_addr    <= '0;
      r_jtag_wdata   <= '0;
      r_jtag_done    <= 1'b0;
      r_jtag_overrun <= 1'b0;
      r_jtag_rdata   <= '0;
    end else begin
      r_jtag_done <= w_jtag_complete;
      if (w_jtag_accept) begin
        r_jtag_pend  <= 1'b1;
        r_jtag_write <= jtag_write;
        r_jtag_addr  <= jtag_addr;
        r_jtag_wdata <= jtag_wdata;
      end else if (w_jtag_complete) begin
        r_jtag_pend <= 1'b0;
      end
      if (jtag_req && r_jtag_pend) begin
        r_jtag_overrun <= 1'b1;
      end else if (jtag_clr_overrun) begin
        r_jtag_overrun <= 1'b0;
      end
      if (w_jtag_complete && !r_is_write) begin
        r_jtag_rdata <= ram_rdata;
      end
    end
  end

  assign jtag_rdata   = r_jtag_rdata;
  assign jtag_done    = r_jtag_done;
  assign jtag_busy    = r_jtag_pend;
  assign jtag_overrun = r_jtag_overrun;

  // --------------------------------------------------------------------------
  // RAM port: live selection during ISSUE, last issued value otherwise
  // --------------------------------------------------------------------------
  assign w_issue_addr  = (r_grant == C_GNT_JTAG) ? r_jtag_addr  : av_address;
  assign w_issue_be    = (r_grant == C_GNT_JTAG) ? 4'hF         : av_byteenable;
  assign w_issue_wdata = (r_grant == C_GNT_JTAG) ? r_jtag_wdata : av_writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_addr_hold  <= '0;
      r_ram_be_hold    <= '0;
      r_ram_wdata_hold <= '0;
    end else if (w_issue) begin
      r_ram_addr_hold  <= w_issue_addr;
      r_ram_be_hold    <= w_issue_be;
      r_ram_wdata_hold <= w_issue_wdata;
    end
  end

  assign ram_addr       = w_issue ? w_issue_addr  : r_ram_addr_hold;
  assign ram_byteenable = w_issue ? w_issue_be    : r_ram_be_hold;
  assign ram_wdata      = w_issue ? w_issue_wdata : r_ram_wdata_hold;
  assign ram_wren       = w_issue && r_is_write;

  assign av_waitrequest = !(w_complete && (r_grant == C_GNT_AV));
  assign av_readdata    = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dircc_node_debug_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dircc_node_debug_mem_arbiter
// Brief    : Directed + randomized bench with a transaction-level arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dircc_node_debug_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        jtag_req, jtag_write, jtag_clr_overrun;
  logic [7:0]  jtag_addr;
  logic [31:0] jtag_wdata;
  logic [31:0] jtag_rdata;
  logic        jtag_done, jtag_busy, jtag_overrun;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int n_vec;
  int n_err;
  int wren_cnt;

  dircc_node_debug_mem_arbiter #(.ADDR_W(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .jtag_req         (jtag_req),
    .jtag_write       (jtag_write),
    .jtag_addr        (jtag_addr),
    .jtag_wdata       (jtag_wdata),
    .jtag_clr_overrun (jtag_clr_overrun),
    .jtag_rdata       (jtag_rdata),
    .jtag_done        (jtag_done),
    .jtag_busy        (jtag_busy),
    .jtag_overrun     (jtag_overrun),
    .av_address       (av_address),
    .av_read          (av_read),
    .av_write         (av_write),
    .av_writedata     (av_writedata),
    .av_byteenable    (av_byteenable),
    .av_readdata      (av_readdata),
    .av_waitrequest   (av_waitrequest),
    .ram_addr         (ram_addr),
    .ram_wren         (ram_wren),
    .ram_byteenable   (ram_byteenable),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // OCI RAM: registered read, byte-enabled write
  logic [31:0] ram_mem [0:255];
  always @(posedge clk) begin
    if (ram_wren) begin
      wren_cnt <= wren_cnt + 1;
      for (int b = 0; b < 4; b++)
        if (ram_byteenable[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Reference model: one access at a time, preceded by an idle slot; a write
  // lasts one cycle, a read two; ties go to whoever was not served last.
  // --------------------------------------------------------------------------
  logic [31:0] m_mem [0:255];
  bit          m_active, m_jtag, m_wr, m_last_jtag;
  int          m_phase;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  bit          m_pend, m_pwr;
  logic [7:0]  m_paddr;
  logic [31:0] m_pdata;
  bit          m_done, m_ovr;
  logic [31:0] m_rdata;

  always @(negedge clk) begin : model
    bit issue, compl, ewr, ewait, old_pend, av_req, take_j;
    if (!reset_n) begin
      m_active = 0; m_pend = 0; m_done = 0; m_ovr = 0; m_rdata = '0; m_last_jtag = 0;
    end
    issue = m_active && (m_phase == 0);
    compl = m_active && (m_wr ? (m_phase == 0) : (m_phase == 1));
    ewr   = issue && m_wr;
    ewait = !(compl && !m_jtag);
    chk("waitrequest", 32'(av_waitrequest), 32'(ewait));
    chk("ram_wren", 32'(ram_wren), 32'(ewr));
    chk("jtag_busy", 32'(jtag_busy), 32'(m_pend));
    chk("jtag_done", 32'(jtag_done), 32'(m_done));
    chk("jtag_overrun", 32'(jtag_overrun), 32'(m_ovr));
    chk("jtag_rdata", jtag_rdata, m_rdata);
    if (issue) begin
      chk("ram_addr", 32'(ram_addr), 32'(m_addr));
      if (m_wr) begin
        chk("ram_wdata", ram_wdata, m_wdata);
        chk("ram_byteenable", 32'(ram_byteenable), 32'(m_be));
      end
    end
    if (compl && !m_jtag && !m_wr) chk("av_readdata", av_readdata, m_mem[m_addr]);

    if (reset_n) begin
      old_pend = m_pend;
      av_req   = av_read || av_write;
      m_done   = compl && m_jtag;
      if (ewr)
        for (int b = 0; b < 4; b++)
          if (m_be[b]) m_mem[m_addr][b*8 +: 8] = m_wdata[b*8 +: 8];
      if (compl && m_jtag) begin
        m_pend = 0;
        if (!m_wr) m_rdata = m_mem[m_addr];
      end
      if (jtag_req && old_pend) m_ovr = 1;
      else if (jtag_clr_overrun) m_ovr = 0;
      if (m_active) begin
        if (compl) m_active = 0;
        else m_phase++;
      end else if (old_pend || av_req) begin
        take_j      = old_pend && (!av_req || !m_last_jtag);
        m_jtag      = take_j;
        m_last_jtag = take_j;
        m_active    = 1;
        m_phase     = 0;
        if (take_j) begin
          m_wr = m_pwr; m_addr = m_paddr; m_wdata = m_pdata; m_be = 4'hF;
        end else begin
          m_wr = av_write; m_addr = av_address; m_wdata = av_writedata; m_be = av_byteenable;
        end
      end
      if (jtag_req && !old_pend) begin
        m_pend = 1; m_pwr = jtag_write; m_paddr = jtag_addr; m_pdata = jtag_wdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    bit          seq [0:15];
    int          nseq, nj, na, w0, k;
    bit          comp, av_started, av_act;

    n_vec = 0; n_err = 0; wren_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      m_mem[i]   = '0;
    end
    ram_rdata = '0;
    m_phase = 0; m_jtag = 0; m_wr = 0; m_addr = '0; m_wdata = '0; m_be = '0;
    m_pwr = 0; m_paddr = '0; m_pdata = '0;
    reset_n = 0; jtag_req = 0; jtag_write = 0; jtag_clr_overrun = 0;
    jtag_addr = '0; jtag_wdata = '0;
    av_address = '0; av_read = 0; av_write = 0; av_writedata = '0; av_byteenable = '0;
    repeat (3) step();
    reset_n = 1;
    step();

    // Reset state with no requests
    @(negedge clk);
    chk("rst_waitrequest", 32'(av_waitrequest), 32'd1);
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_jtag_done", 32'(jtag_done), 32'd0);
    chk("rst_jtag_busy", 32'(jtag_busy), 32'd0);
    chk("rst_jtag_overrun", 32'(jtag_overrun), 32'd0);
    chk("rst_jtag_rdata", jtag_rdata, 32'd0);

    // JTAG write 0x12 then read back
    step();
    jtag_req = 1; jtag_write = 1; jtag_addr = 8'h12; jtag_wdata = 32'hDEADBEEF;
    step(); jtag_req = 0;
    @(negedge clk); chk("jw_busy", 32'(jtag_busy), 32'd1);
    step();
    @(negedge clk);
    chk("jw_wren_t2", 32'(ram_wren), 32'd1);
    chk("jw_be", 32'(ram_byteenable), 32'hF);
    chk("jw_addr", 32'(ram_addr), 32'h12);
    chk("jw_wdata", ram_wdata, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("jw_done_t3", 32'(jtag_done), 32'd1);
    chk("jw_busy_fall", 32'(jtag_busy), 32'd0);
    step();
    jtag_req = 1; jtag_write = 0; jtag_addr = 8'h12;
    step(); jtag_req = 0;
    step(); @(negedge clk); chk("jr_wren", 32'(ram_wren), 32'd0);
    step(); @(negedge clk); chk("jr_done_t3", 32'(jtag_done), 32'd0);
    step(); @(negedge clk);
    chk("jr_done_t4", 32'(jtag_done), 32'd1);
    chk("jr_rdata", jtag_rdata, 32'hDEADBEEF);

    // Avalon partial write 0x05, then read back
    step();
    av_write = 1; av_address = 8'h05; av_byteenable = 4'b0011; av_writedata = 32'h1234ABCD;
    @(negedge clk); chk("aw_wait_a0", 32'(av_waitrequest), 32'd1);
    step(); @(negedge clk);
    chk("aw_wait_a1", 32'(av_waitrequest), 32'd0);
    chk("aw_be", 32'(ram_byteenable), 32'h3);
    step();
    av_write = 0; av_read = 1; av_address = 8'h05;
    step(); @(negedge clk); chk("ar_wait_a1", 32'(av_waitrequest), 32'd1);
    step(); @(negedge clk);
    chk("ar_wait_a2", 32'(av_waitrequest), 32'd0);
    chk("ar_readdata", av_readdata, 32'h0000ABCD);
    step(); av_read = 0;

    // Sustained contention: grants must alternate, JTAG first
    step();
    nseq = 0; nj = 1; na = 0; av_started = 0;
    jtag_req = 1; jtag_write = 0; jtag_addr = 8'h40;
    for (int cyc = 0; cyc < 100 && nseq < 8; cyc++) begin
      @(negedge clk);
      comp = 0;
      if (jtag_done && nseq < 16) begin seq[nseq] = 1; nseq++; end
      if (av_read && !av_waitrequest && nseq < 16) begin seq[nseq] = 0; nseq++; na++; comp = 1; end
      step();
      jtag_req = 0;
      if (!jtag_busy && nj < 4) begin
        jtag_req = 1; jtag_addr = 8'(8'h40 + nj); nj++;
      end
      if (!av_started) begin
        av_read = 1; av_address = 8'h50; av_started = 1;
      end else if (comp) begin
        if (na >= 4) av_read = 0;
        else av_address = 8'(8'h50 + na);
      end
    end
    av_read = 0; jtag_req = 0;
    chk("arb_count", 32'(nseq), 32'd8);
    for (int i = 0; i < 8 && i < nseq; i++)
      chk("arb_order", 32'(seq[i]), 32'((i % 2) == 0));
    repeat (2) step();

    // Overrun: back-to-back request dropped, set beats clear
    w0 = wren_cnt;
    jtag_req = 1; jtag_write = 1; jtag_addr = 8'h30; jtag_wdata = 32'h1;
    step();
    jtag_addr = 8'h31; jtag_wdata = 32'h2;
    step();
    jtag_clr_overrun = 1;
    @(negedge clk); chk("ovr_set", 32'(jtag_overrun), 32'd1);
    step();
    jtag_req = 0; jtag_clr_overrun = 0;
    @(negedge clk); chk("ovr_set_wins", 32'(jtag_overrun), 32'd1);
    step(); jtag_clr_overrun = 1;
    step(); jtag_clr_overrun = 0;
    @(negedge clk);
    chk("ovr_cleared", 32'(jtag_overrun), 32'd0);
    chk("ovr_one_access", 32'(wren_cnt - w0), 32'd1);

    // Reset during RDATA of an Avalon read
    step();
    av_read = 1; av_address = 8'h12;
    step();
    step();
    reset_n = 0; av_read = 0;
    @(negedge clk);
    chk("rst_mid_wait", 32'(av_waitrequest), 32'd1);
    chk("rst_mid_done", 32'(jtag_done), 32'd0);
    step(); reset_n = 1;
    step();
    av_read = 1; av_address = 8'h05;
    step(); step();
    @(negedge clk);
    chk("post_rst_wait", 32'(av_waitrequest), 32'd0);
    chk("post_rst_rdata", av_readdata, 32'h0000ABCD);
    step(); av_read = 0;

    // Randomized traffic from both requesters
    av_act = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      comp = av_act && !av_waitrequest;
      step();
      if (!reset_n) reset_n = 1;
      else if ($urandom_range(0, 599) == 0) reset_n = 0;
      if (comp) begin av_act = 0; av_read = 0; av_write = 0; end
      if (!reset_n) begin
        av_act = 0; av_read = 0; av_write = 0; jtag_req = 0; jtag_clr_overrun = 0;
      end else begin
        if (!av_act && $urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, 7);
          av_act        = 1;
          av_write      = (k < 3) || (k == 7);
          av_read       = (k >= 3);
          av_address    = 8'($urandom_range(0, 15));
          av_writedata  = $urandom;
          av_byteenable = 4'($urandom_range(0, 15));
        end
        jtag_req         = ($urandom_range(0, 4) == 0);
        jtag_write       = 1'($urandom_range(0, 1));
        jtag_addr        = 8'($urandom_range(0, 15));
        jtag_wdata       = $urandom;
        jtag_clr_overrun = ($urandom_range(0, 15) == 0);
      end
    end
    av_read = 0; av_write = 0; jtag_req = 0; jtag_clr_overrun = 0;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
